// File: rtl/mac_feeder.sv
// Packs (attr, coeff) byte beats into 3-lane words, launches the MAC and returns its result.
// Optional MAC_FEEDER_ACCUM_EN: sum per-word results (saturating) and return one per vector.
module mac_feeder #(
    parameter int unsigned ATTR_WIDTH      = 24,
    parameter int unsigned RAM1_DATA_WIDTH = 24,
    parameter int unsigned LANE_W          = 8,
    parameter int unsigned ACC_WIDTH       = 20,
    parameter int unsigned MAC_LAT         = 4
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [LANE_W-1:0]          s_attr,
    input  logic [LANE_W-1:0]          s_coeff,
    input  logic                       s_last,
    output logic [ATTR_WIDTH-1:0]      mac_attr,
    output logic [RAM1_DATA_WIDTH-1:0] mac_coeff,
    output logic                       mac_start,
    input  logic [ACC_WIDTH-1:0]       mac_acc,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ACC_WIDTH-1:0]       res_data,
    output logic                       res_last
);

    typedef enum logic [2:0] {StFill, StLaunch, StWait, StCapture, StHold} state_e;

    localparam int unsigned CntW = (MAC_LAT > 2) ? $clog2(MAC_LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAC_LAT - 2);

    state_e                     state_q, state_d;
    logic [1:0]                 lane_idx_q, lane_idx_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       last_q, last_d;
    logic [ATTR_WIDTH-1:0]      attr_q, attr_d;
    logic [RAM1_DATA_WIDTH-1:0] coeff_q, coeff_d;
    logic                       s_ready_q, s_ready_d;
    logic                       mac_start_q, mac_start_d;
    logic                       res_valid_q, res_valid_d;
    logic [ACC_WIDTH-1:0]       res_data_q, res_data_d;
    logic                       res_last_q, res_last_d;
    int unsigned                attr_base, coeff_base;

`ifdef MAC_FEEDER_ACCUM_EN
    localparam logic [ACC_WIDTH:0] AccMax = {1'b0, {ACC_WIDTH{1'b1}}};
    logic [ACC_WIDTH:0] sum_q, sum_d, sum_raw, sum_sat;
`endif

    always_comb begin
        state_d     = state_q;
        lane_idx_d  = lane_idx_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        attr_d      = attr_q;
        coeff_d     = coeff_q;
        s_ready_d   = s_ready_q;
        mac_start_d = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_last_d  = res_last_q;
        // Lanes fill MSB-first: beat 0 lands in the top byte.
        attr_base   = ATTR_WIDTH - 1 - 32'(lane_idx_q) * LANE_W;
        coeff_base  = RAM1_DATA_WIDTH - 1 - 32'(lane_idx_q) * LANE_W;
`ifdef MAC_FEEDER_ACCUM_EN
        sum_d   = sum_q;
        sum_raw = sum_q + {1'b0, mac_acc};
        sum_sat = (sum_raw > AccMax) ? AccMax : sum_raw;
`endif
        unique case (state_q)
            StFill: begin
                if (s_valid && s_ready_q) begin
                    if (lane_idx_q == 2'd0) begin
                        attr_d  = '0;
                        coeff_d = '0;
                    end
                    attr_d[attr_base -: LANE_W]   = s_attr;
                    coeff_d[coeff_base -: LANE_W] = s_coeff;
                    if (s_last || lane_idx_q == 2'd2) begin
                        lane_idx_d  = 2'd0;
                        last_d      = s_last;
                        s_ready_d   = 1'b0;
                        mac_start_d = 1'b1;
                        state_d     = StLaunch;
                    end else begin
                        lane_idx_d = lane_idx_q + 2'd1;
                    end
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
`ifdef MAC_FEEDER_ACCUM_EN
                sum_d = sum_sat;
                if (last_q) begin
                    res_data_d  = sum_sat[ACC_WIDTH-1:0];
                    res_last_d  = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    s_ready_d = 1'b1;
                    state_d   = StFill;
                end
`else
                res_data_d  = mac_acc;
                res_last_d  = last_q;
                res_valid_d = 1'b1;
                state_d     = StHold;
`endif
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    s_ready_d   = 1'b1;
                    state_d     = StFill;
`ifdef MAC_FEEDER_ACCUM_EN
                    sum_d = '0;
`endif
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StFill;
            lane_idx_q  <= 2'd0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            attr_q      <= '0;
            coeff_q     <= '0;
            s_ready_q   <= 1'b1;
            mac_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
`ifdef MAC_FEEDER_ACCUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lane_idx_q  <= lane_idx_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            attr_q      <= attr_d;
            coeff_q     <= coeff_d;
            s_ready_q   <= s_ready_d;
            mac_start_q <= mac_start_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
`ifdef MAC_FEEDER_ACCUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign s_ready   = s_ready_q;
    assign mac_attr  = attr_q;
    assign mac_coeff = coeff_q;
    assign mac_start = mac_start_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Randomised bench for mac_feeder: a latency-accurate MAC stand-in plus a vector-level reference
// model (packing by arithmetic, dot products, optional saturating vector sum).
module tb_mac_feeder;

    localparam int unsigned MacLat = 4;
    localparam int unsigned AccMax = 32'hFFFFF;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_attr, s_coeff;
    logic [23:0] mac_attr, mac_coeff;
    logic        mac_start;
    logic [19:0] mac_acc;
    logic        res_valid, res_ready, res_last;
    logic [19:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;
    int model_sum = 0;

    mac_feeder #(
        .ATTR_WIDTH     (24),
        .RAM1_DATA_WIDTH(24),
        .LANE_W         (8),
        .ACC_WIDTH      (20),
        .MAC_LAT        (MacLat)
    ) u_dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_attr   (s_attr),
        .s_coeff  (s_coeff),
        .s_last   (s_last),
        .mac_attr (mac_attr),
        .mac_coeff(mac_coeff),
        .mac_start(mac_start),
        .mac_acc  (mac_acc),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_last (res_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] lane_dot(input logic [23:0] a, input logic [23:0] c);
        int s = 0;
        for (int k = 0; k < 3; k++) s += int'(a[8*k +: 8]) * int'(c[8*k +: 8]);
        return 20'(s);
    endfunction

    // MAC stand-in: acc is valid only in the cycle MAC_LAT cycles after the start pulse.
    int          mac_k = 0;
    int          mac_k_nx;
    logic [19:0] mac_pend;
    int          start_cnt = 0;
    int          bad_start = 0;
    logic        rst_prev = 1'b1;

    always_comb mac_k_nx = mac_start ? 1 : ((mac_k > 0) ? mac_k + 1 : 0);

    always @(posedge clk) begin
        rst_prev <= rst_in;
        if (mac_start && (rst_in || rst_prev)) bad_start <= bad_start + 1;
        if (mac_start) begin
            start_cnt <= start_cnt + 1;
            mac_pend  <= lane_dot(mac_attr, mac_coeff);
        end
        mac_k   <= rst_in ? 0 : mac_k_nx;
        mac_acc <= (mac_k_nx == MacLat && !rst_in) ? mac_pend : 20'($urandom);
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_s_ready"}, s_ready, 1);
        check_eq({tag, "_mac_attr"}, mac_attr, 0);
        check_eq({tag, "_mac_coeff"}, mac_coeff, 0);
        check_eq({tag, "_mac_start"}, mac_start, 0);
        check_eq({tag, "_res_data"}, res_data, 0);
        check_eq({tag, "_res_last"}, res_last, 0);
    endtask

    // Sends one word of n beats; rst_at>0 pulses reset that many cycles after LAUNCH.
    task automatic send_word(input int n, input logic [7:0] a0, a1, a2, c0, c1, c2,
                             input bit last, input int gap, input int hold, input int rst_at);
        logic [7:0] a[3];
        logic [7:0] c[3];
        int exp_attr = 0, exp_coeff = 0, dot = 0, tmo, start0;
        bit expect_res;
        int exp_data;
        bit exp_last;
        a = '{a0, a1, a2};
        c = '{c0, c1, c2};
        for (int k = 0; k < n; k++) begin
            exp_attr  += int'(a[k]) << (8 * (2 - k));
            exp_coeff += int'(c[k]) << (8 * (2 - k));
            dot       += int'(a[k]) * int'(c[k]);
        end
        start0 = start_cnt;
        for (int k = 0; k < n; k++) begin
            repeat (gap) begin
                res_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_attr  = a[k];
            s_coeff = c[k];
            s_last  = last && (k == n - 1);
            tmo = 0;
            while (!s_ready && tmo < 50) begin
                @(negedge clk);
                tmo++;
            end
            check_eq("beat_accept", s_ready, 1);
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_attr  = 8'($urandom);
            s_coeff = 8'($urandom);
        end
        // Now in the LAUNCH cycle.
        check_eq("launch_mac_start", mac_start, 1);
        check_eq("launch_s_ready", s_ready, 0);
        check_eq("launch_mac_attr", mac_attr, exp_attr);
        check_eq("launch_mac_coeff", mac_coeff, exp_coeff);

`ifdef MAC_FEEDER_ACCUM_EN
        model_sum = (model_sum + dot > AccMax) ? AccMax : model_sum + dot;
        expect_res = last;
        exp_data   = model_sum;
        exp_last   = 1'b1;
`else
        expect_res = 1'b1;
        exp_data   = dot;
        exp_last   = last;
`endif

        if (rst_at > 0) begin
            repeat (rst_at) @(negedge clk);
            rst_in = 1'b1;
            #1;
            check_reset_outputs("midrst");
            @(negedge clk);
            rst_in = 1'b0;
            model_sum = 0;
            repeat (MacLat + 3) begin
                @(negedge clk);
                check_eq("post_rst_res_valid", res_valid, 0);
                check_eq("post_rst_s_ready", s_ready, 1);
            end
            return;
        end

        for (int cyc = 2; cyc <= MacLat + 1; cyc++) begin
            res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("wait_res_valid", res_valid, 0);
            check_eq("wait_s_ready", s_ready, 0);
            check_eq("wait_mac_attr", mac_attr, exp_attr);
        end
        res_ready = 1'b0;
        @(negedge clk);
        check_eq("start_pulses", start_cnt - start0, 1);
        if (expect_res) begin
            check_eq("res_valid_latency", res_valid, 1);
            check_eq("res_data", res_data, exp_data);
            check_eq("res_last", res_last, exp_last);
            repeat (hold) begin
                @(negedge clk);
                check_eq("hold_res_valid", res_valid, 1);
                check_eq("hold_res_data", res_data, exp_data);
                check_eq("hold_res_last", res_last, exp_last);
                check_eq("hold_s_ready", s_ready, 0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check_eq("post_hs_res_valid", res_valid, 0);
            check_eq("post_hs_s_ready", s_ready, 1);
            model_sum = 0;
        end else begin
            check_eq("inter_res_valid", res_valid, 0);
            check_eq("inter_s_ready", s_ready, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in    = 1'b1;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_attr    = 8'h0;
        s_coeff   = 8'h0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        @(negedge clk);
        check_eq("idle_s_ready", s_ready, 1);

        send_word(3, 1, 2, 3, 4, 5, 6, 1, 0, 0, 0);
        send_word(2, 10, 20, 0, 3, 4, 0, 1, 0, 0, 0);
        send_word(3, 1, 2, 3, 4, 5, 6, 1, 0, 5, 0);
        send_word(3, 1, 2, 3, 4, 5, 6, 1, 0, 0, 2);
        send_word(3, 1, 2, 3, 4, 5, 6, 1, 0, 0, 0);
        send_word(3, 1, 2, 3, 4, 5, 6, 1, 3, 0, 0);
        send_word(1, 200, 0, 0, 7, 0, 0, 1, 1, 1, 0);
        // Accumulation pattern: 32 + 110 over one vector.
        send_word(3, 1, 2, 3, 4, 5, 6, 0, 0, 0, 0);
        send_word(2, 10, 20, 0, 3, 4, 0, 1, 0, 0, 0);
        // Saturation pattern: six full-scale words, last on the sixth.
        for (int w = 0; w < 6; w++)
            send_word(3, 255, 255, 255, 255, 255, 255, (w == 5), 0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            int n;
            bit lst;
            n   = $urandom_range(1, 3);
            lst = (n < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            send_word(n, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom), lst, $urandom_range(0, 3),
                      $urandom_range(0, 4), 0);
        end
        // Close any open accumulation so the last vector result is checked too.
        send_word(1, 9, 0, 0, 9, 0, 0, 1, 0, 0, 0);

        check_eq("mac_start_in_reset", bad_start, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
